// File: rtl/mouse_tracker.sv
// mouse_tracker: PS/2 mouse host controller. Runs the device init script
// (reset, optional IntelliMouse wheel probe, enable streaming), then
// assembles 3- or 4-byte movement packets into a clamped cursor position,
// button state and wheel delta.
module mouse_tracker #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int POS_W     = 10,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 100,
  parameter int WHEEL_EN  = 0,
  parameter int SKIP_INIT = 0,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done_tick,
  input  logic             tx_done_tick,
  output logic             tx_wr,
  output logic [7:0]       tx_din,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic [2:0]       btn,
  output logic [3:0]       wheel,
  output logic             packet_valid,
  output logic             streaming,
  output logic             wheel_active
);

  localparam int       TMR_W     = $clog2(TIMEOUT + 1);
  localparam int       SW        = POS_W + 2;
  localparam bit       WHEEL_ON  = (WHEEL_EN != 0);
  localparam bit       SKIP_ON   = (SKIP_INIT != 0);
  localparam logic [4:0] LAST_STEP = WHEEL_ON ? 5'd20 : 5'd5;

  // Script step kinds: write a command, read an exact reply, read the device id.
  localparam logic [1:0] KIND_WR = 2'd0;
  localparam logic [1:0] KIND_RD = 2'd1;
  localparam logic [1:0] KIND_ID = 2'd2;

  typedef enum logic {M_SCRIPT = 1'b0, M_PACKET = 1'b1} mode_e;

  // Script table {kind, code}. Without the wheel probe, steps 4 and 5 jump
  // straight to the final "enable streaming" pair at entries 19 and 20.
  function automatic logic [9:0] script_entry(input logic [4:0] step);
    logic [4:0] s;
    if (!WHEEL_ON && (step >= 5'd4)) s = step + 5'd15;
    else                             s = step;
    case (s)
      5'd0:    script_entry = {KIND_WR, 8'hFF};
      5'd1:    script_entry = {KIND_RD, 8'hFA};
      5'd2:    script_entry = {KIND_RD, 8'hAA};
      5'd3:    script_entry = {KIND_RD, 8'h00};
      5'd4:    script_entry = {KIND_WR, 8'hF3};
      5'd5:    script_entry = {KIND_RD, 8'hFA};
      5'd6:    script_entry = {KIND_WR, 8'hC8};
      5'd7:    script_entry = {KIND_RD, 8'hFA};
      5'd8:    script_entry = {KIND_WR, 8'hF3};
      5'd9:    script_entry = {KIND_RD, 8'hFA};
      5'd10:   script_entry = {KIND_WR, 8'h64};
      5'd11:   script_entry = {KIND_RD, 8'hFA};
      5'd12:   script_entry = {KIND_WR, 8'hF3};
      5'd13:   script_entry = {KIND_RD, 8'hFA};
      5'd14:   script_entry = {KIND_WR, 8'h50};
      5'd15:   script_entry = {KIND_RD, 8'hFA};
      5'd16:   script_entry = {KIND_WR, 8'hF2};
      5'd17:   script_entry = {KIND_RD, 8'hFA};
      5'd18:   script_entry = {KIND_ID, 8'h00};
      5'd19:   script_entry = {KIND_WR, 8'hF4};
      5'd20:   script_entry = {KIND_RD, 8'hFA};
      default: script_entry = {KIND_RD, 8'hFA};
    endcase
  endfunction

  // Saturate a signed wide sum into 0..hi.
  function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v, input int hi);
    logic signed [SW-1:0] hi_s;
    hi_s = SW'(hi);
    if (v[SW-1])        clamp = '0;
    else if (v > hi_s)  clamp = hi_s[POS_W-1:0];
    else                clamp = v[POS_W-1:0];
  endfunction

  mode_e            mode_q, mode_d;
  logic [4:0]       step_q, step_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]       btn_q, btn_d;
  logic [3:0]       wheel_q, wheel_d;
  logic             pv_q, pv_d;
  logic             tx_wr_q, tx_wr_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             streaming_q, streaming_d;
  logic             wa_q, wa_d;

  logic [9:0]           cur_entry, nxt_entry;
  logic [1:0]           cur_kind;
  logic [7:0]           cur_code;
  logic                 any_tick, counting, to_hit, fire;
  logic                 adv, restart, do_apply;
  logic [7:0]           pkt_b2;
  logic [8:0]           dx9, dy9;
  logic signed [SW-1:0] dx_ext, dy_ext, x_sum, y_sum;

  assign cur_entry = script_entry(step_q);
  assign cur_kind  = cur_entry[9:8];
  assign cur_code  = cur_entry[7:0];
  assign any_tick  = rx_done_tick | tx_done_tick;
  assign counting  = (mode_q == M_SCRIPT) || (idx_q != 2'd0);
  assign to_hit    = (tmr_q == TMR_W'(TIMEOUT - 1));
  assign fire      = counting && !any_tick && to_hit;

  // In 3-byte mode the third byte is still on rx_data when the packet is applied.
  assign pkt_b2 = (idx_q == 2'd2) ? rx_data : b2_q;
  assign dx9    = {b0_q[4], b1_q};
  assign dy9    = {b0_q[5], pkt_b2};
  assign dx_ext = b0_q[6] ? '0 : {{(SW-9){dx9[8]}}, dx9};
  assign dy_ext = b0_q[7] ? '0 : {{(SW-9){dy9[8]}}, dy9};
  assign x_sum  = $signed({2'b00, x_q}) + dx_ext;
  assign y_sum  = $signed({2'b00, y_q}) - dy_ext;

  // Next-state: init script sequencing, packet assembly, timeout and cursor update.
  always_comb begin
    mode_d      = mode_q;
    step_d      = step_q;
    idx_d       = idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    x_d         = x_q;
    y_d         = y_q;
    btn_d       = btn_q;
    wheel_d     = wheel_q;
    pv_d        = 1'b0;
    tx_wr_d     = tx_wr_q;
    tx_din_d    = tx_din_q;
    streaming_d = streaming_q;
    wa_d        = wa_q;
    adv         = 1'b0;
    restart     = 1'b0;
    do_apply    = 1'b0;
    nxt_entry   = cur_entry;

    if (any_tick || !counting || to_hit) tmr_d = '0;
    else                                 tmr_d = tmr_q + TMR_W'(1);

    if (mode_q == M_SCRIPT) begin
      case (cur_kind)
        KIND_WR: begin
          adv     = tx_done_tick;
          restart = fire;
        end
        KIND_RD: begin
          adv     = rx_done_tick && (rx_data == cur_code);
          restart = (rx_done_tick && (rx_data != cur_code)) || fire;
        end
        KIND_ID: begin
          adv     = rx_done_tick;
          restart = fire;
          if (rx_done_tick) wa_d = (rx_data == 8'h03);
          else              wa_d = wa_q;
        end
        default: begin
          adv     = 1'b0;
          restart = 1'b1;
        end
      endcase

      if (restart) begin
        step_d = 5'd0;
        wa_d   = 1'b0;
      end else if (adv) begin
        if (step_q == LAST_STEP) begin
          mode_d      = M_PACKET;
          step_d      = 5'd0;
          idx_d       = 2'd0;
          streaming_d = 1'b1;
        end else begin
          step_d = step_q + 5'd1;
        end
      end else begin
        step_d = step_q;
      end
    end else begin
      if (rx_done_tick) begin
        case (idx_q)
          2'd0: begin
            if (rx_data[3]) begin
              b0_d  = rx_data;
              idx_d = 2'd1;
            end else begin
              idx_d = 2'd0;
            end
          end
          2'd1: begin
            b1_d  = rx_data;
            idx_d = 2'd2;
          end
          2'd2: begin
            if (wa_q) begin
              b2_d  = rx_data;
              idx_d = 2'd3;
            end else begin
              do_apply = 1'b1;
              idx_d    = 2'd0;
            end
          end
          2'd3: begin
            do_apply = 1'b1;
            idx_d    = 2'd0;
          end
          default: idx_d = 2'd0;
        endcase
      end else if (fire) begin
        idx_d = 2'd0;
      end else begin
        idx_d = idx_q;
      end
    end

    if (do_apply) begin
      x_d     = clamp(x_sum, SCREEN_W - 1);
      y_d     = clamp(y_sum, SCREEN_H - 1);
      btn_d   = b0_q[2:0];
      wheel_d = wa_q ? rx_data[3:0] : 4'h0;
      pv_d    = 1'b1;
    end else begin
      pv_d = 1'b0;
    end

    // tx_wr is a registered level: high for as long as the current step is a write.
    nxt_entry = script_entry(step_d);
    if ((mode_d == M_SCRIPT) && (nxt_entry[9:8] == KIND_WR)) begin
      tx_wr_d  = 1'b1;
      tx_din_d = nxt_entry[7:0];
    end else begin
      tx_wr_d  = 1'b0;
      tx_din_d = tx_din_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= SKIP_ON ? M_PACKET : M_SCRIPT;
      step_q      <= 5'd0;
      idx_q       <= 2'd0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      b2_q        <= 8'h00;
      tmr_q       <= '0;
      x_q         <= POS_W'(INIT_X);
      y_q         <= POS_W'(INIT_Y);
      btn_q       <= 3'b000;
      wheel_q     <= 4'h0;
      pv_q        <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_din_q    <= 8'h00;
      streaming_q <= SKIP_ON;
      wa_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      tmr_q       <= tmr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      btn_q       <= btn_d;
      wheel_q     <= wheel_d;
      pv_q        <= pv_d;
      tx_wr_q     <= tx_wr_d;
      tx_din_q    <= tx_din_d;
      streaming_q <= streaming_d;
      wa_q        <= wa_d;
    end
  end

  assign tx_wr        = tx_wr_q;
  assign tx_din       = tx_din_q;
  assign cursor_x     = x_q;
  assign cursor_y     = y_q;
  assign btn          = btn_q;
  assign wheel        = wheel_q;
  assign packet_valid = pv_q;
  assign streaming    = streaming_q;
  assign wheel_active = wa_q;

endmodule
